branch_predict_unit: RTL
========================

# branch_predict_unit

Parametrised branch resolution and prediction unit for the 5-stage MIPS pipeline.
- IF stage: a direct-mapped branch target buffer (BTB) with saturating direction counters supplies a next-PC prediction.
- ID stage: resolves j/jal/jr/jalr/beq/bne/blez/bgtz/bltz/bgez using forwarded operands, checks the result against the prediction carried from IF, and issues a redirect plus IF/ID flush only on a mispredict.
- The BTB is trained at the end of every resolved, unstalled branch.
- Saturating branch and mispredict counters are exposed for performance monitoring.

## Interface
Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, register data width
- BTB_ENTRIES, 16, BTB depth, power of two, ≥2; IDX_W = log2(BTB_ENTRIES)
- CTR_W, 2, direction counter width, ≥1
- STAT_W, 16, statistics counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- pc_IF  in  ADDR_W  fetch PC
- pred_taken_IF  out  1  predicted taken for pc_IF
- pred_target_IF  out  ADDR_W  predicted target; 0 when not predicted taken
- stall_ID  in  1  ID held this cycle (operands not ready)
- pc_plus4_ID  in  ADDR_W  PC+4 of the ID instruction
- inst_ID  in  32  ID instruction
- fw_br_a, fw_br_b  in  2  operand source select: 0 rdata, 1 data_out_EX, 2 data_from_ALU_MEM, 3 MEM_data_MEM
- rdata_1_ID, rdata_2_ID  in  DATA_W  register file reads (rs, rt)
- data_out_EX, data_from_ALU_MEM, MEM_data_MEM  in  DATA_W  forwarding sources
- redirect  out  1  fetch must load redirect_addr
- redirect_addr  out  ADDR_W  corrected next PC
- flush_IF_ID  out  1  kill the instruction in IF/ID; equals redirect
- branch_count  out  STAT_W  resolved branches, saturating
- mispredict_count  out  STAT_W  redirects issued, saturating

## Operation
- BTB entry: valid, tag = pc[ADDR_W-1:IDX_W+2], target, CTR_W-bit counter. Index = pc[IDX_W+1:2].
- IF lookup is combinational. A hit with counter MSB = 1 drives pred_taken_IF = 1 and pred_target_IF = the stored target. Otherwise both outputs are 0.
- Prediction pipeline registers pred_taken_ID / pred_target_ID:
  - rst clears them to 0.
  - stall_ID holds them.
  - redirect loads them with 0.
  - Otherwise they load pred_taken_IF / pred_target_IF.
- Operands opA (rs) and opB (rt) are selected through the fw_br_a / fw_br_b muxes.
- Decode, by opcode = inst[31:26]:
  - 000010 j, 000011 jal: target {pc_plus4_ID[31:28], inst[25:0], 00}.
  - 000100 beq (opA==opB), 000101 bne (opA!=opB).
  - 000110 blez (opA signed ≤ 0), 000111 bgtz (opA signed > 0).
  - 000001 with rt=00000 is bltz (opA < 0); with rt=00001 it is bgez (opA ≥ 0).
  - 000000 with funct 001000 is jr, with funct 001001 is jalr; both always taken with target opA.
  - Conditional branch target: pc_plus4_ID + (sign_extend(inst[15:0]) << 2), computed mod 2^ADDR_W.
  - Every other instruction is a non-branch.
- Mispredict is asserted for a branch in ID when actual_taken != pred_taken_ID, or when both are taken and the targets differ.
- redirect = mispredict & ~stall_ID & ~rst.
  - redirect_addr = actual_taken ? actual_target : pc_plus4_ID.
  - redirect_addr is 0 when redirect is 0.
- Training happens at the clock edge, only for a branch in ID with ~stall_ID. pc_ID = pc_plus4_ID − 4.
  - jr/jalr: never allocated or updated.
  - Taken, BTB hit: write target, counter saturating increment.
  - Taken, BTB miss: allocate the entry (overwriting any tag) with valid=1, tag, target. Counter = all ones for j/jal, 2^(CTR_W-1) for conditional branches.
  - Not taken, BTB hit: counter saturating decrement; the valid bit remains set.
  - Not taken, BTB miss: no change.
- Statistics: branch_count increments per trained branch, including jr/jalr. mispredict_count increments per redirect. Both hold at 2^STAT_W−1.

## Timing
- Lookup and resolution have zero latency (combinational). A BTB update is visible to pc_IF lookups from the next cycle.
- When IF and ID access the same index in one cycle, the lookup returns the pre-update contents.
- rst (synchronous): one cycle clears all valid bits, counters, statistics and prediction registers. During rst, every output is 0.
- A stalled ID produces no redirect, no training and no statistics update. The branch is re-evaluated every cycle until the stall is released.
- A redirect asserts for exactly the ID cycle; the following cycle sees a bubble in ID (pred regs = 0).

## Test plan
- Cold beq at pc 0x100 (pc_plus4_ID=0x104), imm=4, opA=opB=7 → redirect=1, redirect_addr=0x114, flush=1. The next cycle, pc_IF=0x100 gives pred_taken_IF=1, pred_target_IF=0x114.
- Same beq re-fetched with pred_taken_ID=1, target 0x114 → redirect=0. branch_count=2, mispredict_count=1, counter=2'b11.
- Entry at counter 2'b10 resolved not-taken twice → counter 01 then 00, pred_taken_IF=0. The first of these resolutions redirects to pc_plus4_ID; a third not-taken resolution (pred 0) gives redirect=0.
- j inst=0x08100004 at pc_plus4_ID=0x40000010 → target 0x40400010, counter allocated 2'b11. A bgez with opA=0xFFFFFFFF → not taken; with opA=0 → taken.
- bne with fw_br_a=1, data_out_EX=5, rdata_1_ID=3, rdata_2_ID=5 → not taken (uses 5). jalr with opA=0x2000 → redirect to 0x2000 every execution, with no BTB entry allocated.
- Mispredicting beq held with stall_ID=1 for 3 cycles → redirect=0 and counts unchanged. The cycle stall drops → redirect=1. rst asserted mid-run → all outputs 0, and a subsequent lookup misses.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch prediction (IF-stage BTB lookup) and branch resolution (ID stage)
// for the 5-stage MIPS pipeline. Redirects fetch only on a mispredict and
// trains the BTB with every resolved, unstalled branch.
module branch_predict_unit #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int BTB_ENTRIES = 16,
   parameter int CTR_W       = 2,
   parameter int STAT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_IF,
   output logic              pred_taken_IF,
   output logic [ADDR_W-1:0] pred_target_IF,
   input  logic              stall_ID,
   input  logic [ADDR_W-1:0] pc_plus4_ID,
   input  logic [31:0]       inst_ID,
   input  logic [1:0]        fw_br_a,
   input  logic [1:0]        fw_br_b,
   input  logic [DATA_W-1:0] rdata_1_ID,
   input  logic [DATA_W-1:0] rdata_2_ID,
   input  logic [DATA_W-1:0] data_out_EX,
   input  logic [DATA_W-1:0] data_from_ALU_MEM,
   input  logic [DATA_W-1:0] MEM_data_MEM,
   output logic              redirect,
   output logic [ADDR_W-1:0] redirect_addr,
   output logic              flush_IF_ID,
   output logic [STAT_W-1:0] branch_count,
   output logic [STAT_W-1:0] mispredict_count
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

   // BTB storage
   logic [BTB_ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
   logic [ADDR_W-1:0]      tgt_q [BTB_ENTRIES];
   logic [CTR_W-1:0]       ctr_q [BTB_ENTRIES];

   // Prediction carried from IF into ID, and statistics
   logic              pred_taken_ID_q, pred_taken_ID_d;
   logic [ADDR_W-1:0] pred_target_ID_q, pred_target_ID_d;
   logic [STAT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

   // ---------------- IF lookup ----------------
   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   assign if_idx = pc_IF[IDX_W+1:2];
   assign if_tag = pc_IF[ADDR_W-1:IDX_W+2];
   assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

   assign pred_taken_IF  = ~rst & if_hit & ctr_q[if_idx][CTR_W-1];
   assign pred_target_IF = pred_taken_IF ? tgt_q[if_idx] : '0;

   // ---------------- ID resolution ----------------
   logic [DATA_W-1:0] opA, opB;
   logic [5:0]        opcode, funct;
   logic [4:0]        rt;
   logic [ADDR_W-1:0] br_tgt, j_tgt;
   logic              is_branch, is_jreg, is_jump, actual_taken;
   logic [ADDR_W-1:0] actual_target;
   logic              mispredict;

   // Forwarding muxes for the two branch operands
   always_comb begin
      unique case (fw_br_a)
         2'd0:    opA = rdata_1_ID;
         2'd1:    opA = data_out_EX;
         2'd2:    opA = data_from_ALU_MEM;
         default: opA = MEM_data_MEM;
      endcase
      unique case (fw_br_b)
         2'd0:    opB = rdata_2_ID;
         2'd1:    opB = data_out_EX;
         2'd2:    opB = data_from_ALU_MEM;
         default: opB = MEM_data_MEM;
      endcase
   end

   assign opcode = inst_ID[31:26];
   assign rt     = inst_ID[20:16];
   assign funct  = inst_ID[5:0];
   assign br_tgt = pc_plus4_ID + {{(ADDR_W-18){inst_ID[15]}}, inst_ID[15:0], 2'b00};
   assign j_tgt  = {pc_plus4_ID[ADDR_W-1:28], inst_ID[25:0], 2'b00};

   // Decode branch class, direction and target
   always_comb begin
      is_branch     = 1'b0;
      is_jreg       = 1'b0;
      is_jump       = 1'b0;
      actual_taken  = 1'b0;
      actual_target = br_tgt;
      unique case (opcode)
         6'b000010, 6'b000011: begin
            is_branch     = 1'b1;
            is_jump       = 1'b1;
            actual_taken  = 1'b1;
            actual_target = j_tgt;
         end
         6'b000100: begin
            is_branch    = 1'b1;
            actual_taken = (opA == opB);
         end
         6'b000101: begin
            is_branch    = 1'b1;
            actual_taken = (opA != opB);
         end
         6'b000110: begin
            is_branch    = 1'b1;
            actual_taken = ($signed(opA) <= 0);
         end
         6'b000111: begin
            is_branch    = 1'b1;
            actual_taken = ($signed(opA) > 0);
         end
         6'b000001: begin
            if (rt == 5'b00000) begin
               is_branch    = 1'b1;
               actual_taken = opA[DATA_W-1];
            end else if (rt == 5'b00001) begin
               is_branch    = 1'b1;
               actual_taken = ~opA[DATA_W-1];
            end
         end
         6'b000000: begin
            if (funct == 6'b001000 || funct == 6'b001001) begin
               is_branch     = 1'b1;
               is_jreg       = 1'b1;
               actual_taken  = 1'b1;
               actual_target = ADDR_W'(opA);
            end
         end
         default: ;
      endcase
   end

   assign mispredict = is_branch &
                       ((actual_taken != pred_taken_ID_q) |
                        (actual_taken & pred_taken_ID_q & (actual_target != pred_target_ID_q)));
   assign redirect      = mispredict & ~stall_ID & ~rst;
   assign redirect_addr = redirect ? (actual_taken ? actual_target : pc_plus4_ID) : '0;
   assign flush_IF_ID   = redirect;

   assign branch_count     = rst ? '0 : bcnt_q;
   assign mispredict_count = rst ? '0 : mcnt_q;

   // ---------------- training ----------------
   logic [ADDR_W-1:0] pc_ID;
   logic [IDX_W-1:0]  id_idx;
   logic [TAG_W-1:0]  id_tag;
   logic              id_hit, resolved, train;
   logic              unused_pc_lsbs;

   assign pc_ID          = pc_plus4_ID - ADDR_W'(4);
   assign id_idx         = pc_ID[IDX_W+1:2];
   assign id_tag         = pc_ID[ADDR_W-1:IDX_W+2];
   assign id_hit         = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
   assign resolved       = is_branch & ~stall_ID;
   assign train          = resolved & ~is_jreg;
   assign unused_pc_lsbs = ^{pc_IF[1:0], pc_ID[1:0]};

   // BTB update: allocate on taken miss, strengthen/weaken on hit
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= '0;
      end else if (train) begin
         if (actual_taken) begin
            tgt_q[id_idx] <= actual_target;
            if (id_hit) begin
               if (ctr_q[id_idx] != CTR_MAX) ctr_q[id_idx] <= ctr_q[id_idx] + 1'b1;
            end else begin
               valid_q[id_idx] <= 1'b1;
               tag_q[id_idx]   <= id_tag;
               ctr_q[id_idx]   <= is_jump ? CTR_MAX : CTR_WEAK;
            end
         end else if (id_hit && ctr_q[id_idx] != '0) begin
            ctr_q[id_idx] <= ctr_q[id_idx] - 1'b1;
         end
      end
   end

   // Next state of the IF->ID prediction and the saturating statistics
   always_comb begin
      pred_taken_ID_d  = pred_taken_IF;
      pred_target_ID_d = pred_target_IF;
      if (stall_ID) begin
         pred_taken_ID_d  = pred_taken_ID_q;
         pred_target_ID_d = pred_target_ID_q;
      end else if (redirect) begin
         pred_taken_ID_d  = 1'b0;
         pred_target_ID_d = '0;
      end
      bcnt_d = (resolved && bcnt_q != '1) ? bcnt_q + 1'b1 : bcnt_q;
      mcnt_d = (redirect && mcnt_q != '1) ? mcnt_q + 1'b1 : mcnt_q;
   end

   // Pipeline and statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_taken_ID_q  <= 1'b0;
         pred_target_ID_q <= '0;
         bcnt_q           <= '0;
         mcnt_q           <= '0;
      end else begin
         pred_taken_ID_q  <= pred_taken_ID_d;
         pred_target_ID_q <= pred_target_ID_d;
         bcnt_q           <= bcnt_d;
         mcnt_q           <= mcnt_d;
      end
   end

endmodule
